// File: rtl/mips_perf_monitor_if.sv
// Observation and readout bundle between the MIPS core side and mips_perf_monitor.
// There is no valid/ready handshake. start/stop/clear are single-cycle pulses. Every
// event input is sampled on each rising clock edge. rd_data answers rd_sel one cycle later.
interface mips_perf_monitor_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 start;
   logic                 stop;
   logic                 clear;
   logic                 stall_in;
   logic                 RegWrite_wb_in;
   logic                 Branch_in;
   logic                 Zero_in;
   logic [1:0]           op_FA_in;
   logic [1:0]           op_FB_in;
   logic [2:0]           rd_sel;
   logic [CNT_WIDTH-1:0] rd_data;
   logic [7:0]           ovf;
   logic                 running;
   logic                 done;
   logic [1:0]           state_dbg;

   modport master (
      output start, stop, clear, stall_in, RegWrite_wb_in, Branch_in, Zero_in,
             op_FA_in, op_FB_in, rd_sel,
      input  rd_data, ovf, running, done, state_dbg
   );

   modport slave (
      input  start, stop, clear, stall_in, RegWrite_wb_in, Branch_in, Zero_in,
             op_FA_in, op_FB_in, rd_sel,
      output rd_data, ovf, running, done, state_dbg
   );
endinterface

// File: rtl/mips_perf_monitor.sv
// Start/stop/windowed cycle and event counter bank observing the pipelined MIPS core.
// It has eight counters, sticky overflow flags and a registered 1-cycle readout.
module mips_perf_monitor #(
   parameter int CNT_WIDTH = 32,
   parameter int WINDOW    = 0,
   parameter bit SATURATE  = 1'b1
) (
   input logic                clock,
   input logic                reset,
   mips_perf_monitor_if.slave bus
);
   localparam int                   NUM_CNT = 8;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] WIN_VAL = CNT_WIDTH'(WINDOW);
   localparam bit                   WIN_EN  = (WINDOW != 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [CNT_WIDTH-1:0] cnt_q   [NUM_CNT];
   logic [CNT_WIDTH-1:0] cnt_inc [NUM_CNT];
   logic [NUM_CNT-1:0]   ev;
   logic [NUM_CNT-1:0]   at_max;
   logic [NUM_CNT-1:0]   ovf_q;
   logic [CNT_WIDTH-1:0] rd_data_q;
   logic                 zero_all;
   logic                 count_en;
   logic                 window_hit;

   // Event conditions, indexed to match the counter numbering seen through rd_sel.
   always_comb begin
      ev    = '0;
      ev[0] = 1'b1;
      ev[1] = bus.RegWrite_wb_in;
      ev[2] = bus.stall_in;
      ev[3] = bus.Branch_in;
      ev[4] = bus.Branch_in & bus.Zero_in;
      ev[5] = |bus.op_FA_in;
      ev[6] = |bus.op_FB_in;
      ev[7] = (|bus.op_FA_in) | (|bus.op_FB_in);
   end

   always_comb begin
      at_max = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_inc[i] = cnt_q[i];
         at_max[i]  = (cnt_q[i] == CNT_MAX);
         if (at_max[i]) begin
            cnt_inc[i] = SATURATE ? CNT_MAX : '0;
         end else begin
            cnt_inc[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // The cycle counter always increments in RUN, so its next value tells us the window end.
   always_comb begin
      window_hit = WIN_EN && (cnt_inc[0] == WIN_VAL);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      zero_all = 1'b0;
      count_en = 1'b0;
      if (bus.clear) begin
         state_d  = ST_IDLE;
         zero_all = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_d  = ST_RUN;
                  zero_all = 1'b1;
               end
            end
            ST_RUN: begin
               // The stopping cycle still counts, so the DONE edge applies its increments.
               count_en = 1'b1;
               if (bus.stop || window_hit) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.start) begin
                  state_d  = ST_RUN;
                  zero_all = 1'b1;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               zero_all = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
         ovf_q     <= '0;
         rd_data_q <= '0;
      end else begin
         rd_data_q <= cnt_q[bus.rd_sel];
         if (zero_all) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               cnt_q[i] <= '0;
            end
            ovf_q <= '0;
         end else if (count_en) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               if (ev[i]) begin
                  cnt_q[i] <= cnt_inc[i];
               end
            end
            ovf_q <= ovf_q | (ev & at_max);
         end
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.ovf       = ovf_q;
   assign bus.running   = (state_q == ST_RUN);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mips_perf_monitor.sv
// Bench for mips_perf_monitor. Four configurations share one stimulus stream and are
// compared every cycle against a behavioural model of the counting rules.
module tb_mips_perf_monitor;
   localparam int N_DUT = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic       clock;
   logic       reset;
   logic       start, stop, clear;
   logic       stall_in, RegWrite_wb_in, Branch_in, Zero_in;
   logic [1:0] op_FA_in, op_FB_in;
   logic [2:0] rd_sel;

   logic [31:0] obs_rd   [N_DUT];
   logic [7:0]  obs_ovf  [N_DUT];
   logic        obs_run  [N_DUT];
   logic        obs_done [N_DUT];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Model: per configuration width, window, saturate; counters held as wide integers.
   int              m_w   [N_DUT] = '{32, 32, 8, 8};
   int              m_win [N_DUT] = '{10, 0, 0, 0};
   int              m_sat [N_DUT] = '{1, 1, 1, 0};
   int              m_state [N_DUT];
   longint unsigned m_cnt [N_DUT][8];
   logic [7:0]      m_ovf [N_DUT];
   longint unsigned m_rd  [N_DUT];

   mips_perf_monitor_if #(.CNT_WIDTH(32)) if_a ();
   mips_perf_monitor_if #(.CNT_WIDTH(32)) if_b ();
   mips_perf_monitor_if #(.CNT_WIDTH(8))  if_c ();
   mips_perf_monitor_if #(.CNT_WIDTH(8))  if_d ();

   mips_perf_monitor #(.CNT_WIDTH(32), .WINDOW(10), .SATURATE(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
   mips_perf_monitor #(.CNT_WIDTH(32), .WINDOW(0),  .SATURATE(1'b1)) dut_b (.clock(clock), .reset(reset), .bus(if_b));
   mips_perf_monitor #(.CNT_WIDTH(8),  .WINDOW(0),  .SATURATE(1'b1)) dut_c (.clock(clock), .reset(reset), .bus(if_c));
   mips_perf_monitor #(.CNT_WIDTH(8),  .WINDOW(0),  .SATURATE(1'b0)) dut_d (.clock(clock), .reset(reset), .bus(if_d));

   assign if_a.start = start; assign if_a.stop = stop; assign if_a.clear = clear; assign if_a.stall_in = stall_in;
   assign if_a.RegWrite_wb_in = RegWrite_wb_in; assign if_a.Branch_in = Branch_in; assign if_a.Zero_in = Zero_in;
   assign if_a.op_FA_in = op_FA_in; assign if_a.op_FB_in = op_FB_in; assign if_a.rd_sel = rd_sel;
   assign if_b.start = start; assign if_b.stop = stop; assign if_b.clear = clear; assign if_b.stall_in = stall_in;
   assign if_b.RegWrite_wb_in = RegWrite_wb_in; assign if_b.Branch_in = Branch_in; assign if_b.Zero_in = Zero_in;
   assign if_b.op_FA_in = op_FA_in; assign if_b.op_FB_in = op_FB_in; assign if_b.rd_sel = rd_sel;
   assign if_c.start = start; assign if_c.stop = stop; assign if_c.clear = clear; assign if_c.stall_in = stall_in;
   assign if_c.RegWrite_wb_in = RegWrite_wb_in; assign if_c.Branch_in = Branch_in; assign if_c.Zero_in = Zero_in;
   assign if_c.op_FA_in = op_FA_in; assign if_c.op_FB_in = op_FB_in; assign if_c.rd_sel = rd_sel;
   assign if_d.start = start; assign if_d.stop = stop; assign if_d.clear = clear; assign if_d.stall_in = stall_in;
   assign if_d.RegWrite_wb_in = RegWrite_wb_in; assign if_d.Branch_in = Branch_in; assign if_d.Zero_in = Zero_in;
   assign if_d.op_FA_in = op_FA_in; assign if_d.op_FB_in = op_FB_in; assign if_d.rd_sel = rd_sel;

   assign obs_rd[0] = if_a.rd_data;       assign obs_ovf[0] = if_a.ovf;
   assign obs_rd[1] = if_b.rd_data;       assign obs_ovf[1] = if_b.ovf;
   assign obs_rd[2] = 32'(if_c.rd_data);  assign obs_ovf[2] = if_c.ovf;
   assign obs_rd[3] = 32'(if_d.rd_data);  assign obs_ovf[3] = if_d.ovf;
   assign obs_run[0] = if_a.running; assign obs_done[0] = if_a.done;
   assign obs_run[1] = if_b.running; assign obs_done[1] = if_b.done;
   assign obs_run[2] = if_c.running; assign obs_done[2] = if_c.done;
   assign obs_run[3] = if_d.running; assign obs_done[3] = if_d.done;

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N_DUT; k++) begin
         m_state[k] = M_IDLE;
         m_ovf[k]   = '0;
         m_rd[k]    = 0;
         for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
      end
   endtask

   task automatic model_zero(input int k);
      m_ovf[k] = '0;
      for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
   endtask

   // One clock edge of every configuration, from the inputs presented at that edge.
   task automatic model_step();
      bit              hit [8];
      longint unsigned maxv;
      if (!reset) begin
         model_reset();
      end else begin
         for (int k = 0; k < N_DUT; k++) begin
            maxv    = (64'd1 << m_w[k]) - 1;
            m_rd[k] = m_cnt[k][rd_sel];
            if (clear) begin
               m_state[k] = M_IDLE;
               model_zero(k);
            end else if (m_state[k] != M_RUN) begin
               if (start) begin
                  m_state[k] = M_RUN;
                  model_zero(k);
               end
            end else begin
               hit[0] = 1;
               hit[1] = RegWrite_wb_in;
               hit[2] = stall_in;
               hit[3] = Branch_in;
               hit[4] = Branch_in && Zero_in;
               hit[5] = (op_FA_in != 0);
               hit[6] = (op_FB_in != 0);
               hit[7] = (op_FA_in != 0) || (op_FB_in != 0);
               for (int i = 0; i < 8; i++) begin
                  if (hit[i]) begin
                     if (m_cnt[k][i] == maxv) begin
                        m_ovf[k][i] = 1'b1;
                        m_cnt[k][i] = (m_sat[k] != 0) ? maxv : 0;
                     end else begin
                        m_cnt[k][i] = m_cnt[k][i] + 1;
                     end
                  end
               end
               if (stop || (m_win[k] != 0 && m_cnt[k][0] == longint'(m_win[k])))
                  m_state[k] = M_DONE;
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < N_DUT; k++) begin
         check_eq($sformatf("d%0d rd_data", k), 64'(obs_rd[k]), 64'(m_rd[k]));
         check_eq($sformatf("d%0d ovf", k), 64'(obs_ovf[k]), 64'(m_ovf[k]));
         check_eq($sformatf("d%0d running", k), 64'(obs_run[k]), 64'(m_state[k] == M_RUN));
         check_eq($sformatf("d%0d done", k), 64'(obs_done[k]), 64'(m_state[k] == M_DONE));
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic quiet_inputs();
      start = 0; stop = 0; clear = 0; stall_in = 0; RegWrite_wb_in = 0;
      Branch_in = 0; Zero_in = 0; op_FA_in = 2'b00; op_FB_in = 2'b00;
   endtask

   task automatic pulse_clear();
      clear = 1; tick(); clear = 0;
   endtask

   task automatic pulse_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic read_ctr(input logic [2:0] sel);
      rd_sel = sel;
      tick();
   endtask

   initial begin
      reset = 1'b0;
      rd_sel = 3'd0;
      quiet_inputs();
      model_reset();
      #1;
      for (int k = 0; k < N_DUT; k++) begin
         check_eq($sformatf("reset d%0d rd_data", k), 64'(obs_rd[k]), 64'd0);
         check_eq($sformatf("reset d%0d ovf", k), 64'(obs_ovf[k]), 64'd0);
         check_eq($sformatf("reset d%0d running", k), 64'(obs_run[k]), 64'd0);
         check_eq($sformatf("reset d%0d done", k), 64'(obs_done[k]), 64'd0);
      end
      tick(); tick();
      reset = 1'b1;

      // Windowed run: start at cycle 2, 10 counted cycles.
      tick(); tick();
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         stall_in = (i < 3);
         RegWrite_wb_in = (i < 6);
         tick();
      end
      quiet_inputs();
      check_eq("win done", 64'(obs_done[0]), 64'd1);
      check_eq("win running", 64'(obs_run[0]), 64'd0);
      read_ctr(3'd0); check_eq("win cycles", 64'(obs_rd[0]), 64'd10);
      read_ctr(3'd2); check_eq("win stalls", 64'(obs_rd[0]), 64'd3);
      read_ctr(3'd1); check_eq("win retired", 64'(obs_rd[0]), 64'd6);

      // Free-running run of 20 cycles, stop cycle included.
      pulse_clear();
      pulse_start();
      for (int i = 0; i < 19; i++) tick();
      stop = 1; tick(); stop = 0;
      check_eq("free done", 64'(obs_done[1]), 64'd1);
      read_ctr(3'd0); check_eq("free cycles", 64'(obs_rd[1]), 64'd20);
      pulse_start();
      check_eq("restart running", 64'(obs_run[1]), 64'd1);
      tick();
      check_eq("restart cycles zero", 64'(obs_rd[1]), 64'd0);
      check_eq("restart ovf zero", 64'(obs_ovf[1]), 64'd0);

      // Branch and forwarding events.
      pulse_clear();
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         Branch_in = 1;
         Zero_in = (i < 2);
         op_FA_in = (i < 3) ? 2'b10 : 2'b00;
         op_FB_in = (i >= 2) ? 2'b01 : 2'b00;
         stop = (i == 3);
         tick();
      end
      quiet_inputs();
      read_ctr(3'd3); check_eq("branches", 64'(obs_rd[1]), 64'd4);
      read_ctr(3'd4); check_eq("taken", 64'(obs_rd[1]), 64'd2);
      read_ctr(3'd5); check_eq("fwdA", 64'(obs_rd[1]), 64'd3);
      read_ctr(3'd6); check_eq("fwdB", 64'(obs_rd[1]), 64'd2);
      read_ctr(3'd7); check_eq("fwd_any", 64'(obs_rd[1]), 64'd4);

      // 300 cycles on the 8-bit counters: saturate versus wrap.
      pulse_clear();
      pulse_start();
      for (int i = 0; i < 300; i++) begin
         stop = (i == 299);
         tick();
      end
      stop = 0;
      read_ctr(3'd0);
      check_eq("sat cycles", 64'(obs_rd[2]), 64'd255);
      check_eq("sat ovf0", 64'(obs_ovf[2][0]), 64'd1);
      check_eq("wrap cycles", 64'(obs_rd[3]), 64'd44);
      check_eq("wrap ovf0", 64'(obs_ovf[3][0]), 64'd1);

      // Priority: start with stop in RUN, then clear with start.
      pulse_start();
      tick(); tick(); tick();
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      check_eq("start+stop done", 64'(obs_done[1]), 64'd1);
      clear = 1; start = 1; tick(); clear = 0; start = 0;
      check_eq("clear+start running", 64'(obs_run[1]), 64'd0);
      check_eq("clear+start done", 64'(obs_done[1]), 64'd0);
      for (int s = 0; s < 8; s++) begin
         read_ctr(3'(s));
         check_eq($sformatf("cleared ctr%0d", s), 64'(obs_rd[1]), 64'd0);
      end

      // Asynchronous reset in the middle of a long run.
      pulse_start();
      for (int i = 0; i < 260; i++) tick();
      #3 reset = 1'b0;
      #1;
      for (int k = 0; k < N_DUT; k++) begin
         check_eq($sformatf("abort d%0d rd_data", k), 64'(obs_rd[k]), 64'd0);
         check_eq($sformatf("abort d%0d ovf", k), 64'(obs_ovf[k]), 64'd0);
         check_eq($sformatf("abort d%0d running", k), 64'(obs_run[k]), 64'd0);
      end
      model_reset();
      tick(); tick();
      reset = 1'b1;

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         start = ($urandom_range(0, 19) == 0);
         stop = ($urandom_range(0, 29) == 0);
         clear = ($urandom_range(0, 99) == 0);
         stall_in = $urandom_range(0, 1);
         RegWrite_wb_in = $urandom_range(0, 1);
         Branch_in = $urandom_range(0, 1);
         Zero_in = $urandom_range(0, 1);
         op_FA_in = 2'($urandom_range(0, 3));
         op_FB_in = 2'($urandom_range(0, 3));
         rd_sel = 3'($urandom_range(0, 7));
         tick();
      end
      quiet_inputs();

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mips_perf_monitor.md
Name: mips_perf_monitor

Overview:
- Parametrised cycle and event counter bank that attaches to the pipelined MIPS core's debug outputs.
- It generalises the free-running testbench cycle count into a start/stop/windowed measurement unit with eight event counters, overflow policy and registered readout.
- It sits beside the MIPS instance, in the testbench or the top level.
- It observes the core only; it never drives it.

Parameters:
- CNT_WIDTH, 32: width of every counter and of rd_data (legal range 8..32).
- WINDOW, 0: measurement length in cycles. 0 means the block free-runs until stop.
- SATURATE, 1: overflow policy. 1 means a counter holds at all-ones; 0 means it wraps to 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle pulse; begins a measurement.
- stop  in  1  single-cycle pulse; ends a measurement.
- clear  in  1  synchronous clear; returns the block to IDLE.
- stall_in  in  1  pipeline stall indication from the core.
- RegWrite_wb_in  in  1  writeback-stage register write; used as the retire event.
- Branch_in  in  1  branch in the EX stage.
- Zero_in  in  1  ALU zero flag.
- op_FA_in  in  2  forwarding mux select for operand A; 00 = no forward.
- op_FB_in  in  2  forwarding mux select for operand B; 00 = no forward.
- rd_sel  in  3  selects the counter to read.
- rd_data  out  CNT_WIDTH  registered value of the selected counter.
- ovf  out  8  sticky overflow flags, one per counter.
- running  out  1  high while the state is RUN.
- done  out  1  high while the state is DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all counters=0, rd_data=0, ovf=0, running=0, done=0.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE on stop.
  - RUN -> DONE when WINDOW!=0 and the cycle counter becomes WINDOW.
  - DONE -> RUN on start.
  - Any state -> IDLE on clear.
- Priority: clear > stop > start. In RUN, start alone is ignored. Simultaneous start and stop in RUN gives DONE.
- On every transition into RUN, all counters and ovf are zeroed in the same edge. The first counted cycle is the cycle after start.
- Counters update only while the state is RUN, once per cycle, each +1 when its condition is true:
  - idx0 cycles: always.
  - idx1 retired: RegWrite_wb_in.
  - idx2 stalls: stall_in.
  - idx3 branches: Branch_in.
  - idx4 taken: Branch_in & Zero_in.
  - idx5 fwdA: op_FA_in!=0.
  - idx6 fwdB: op_FB_in!=0.
  - idx7 fwd_any: op_FA_in!=0 or op_FB_in!=0.
- The stop/window cycle is counted: the edge that enters DONE also applies that cycle's increments. With WINDOW=N, DONE holds cycles=N exactly.
- Overflow: an increment while a counter is all-ones sets ovf[idx], which stays set until the next RUN entry, clear or reset. With SATURATE=1 the counter stays all-ones; with SATURATE=0 it becomes 0.
- In IDLE and DONE, counters hold their values and remain readable. After clear, all counters read 0.
- rd_data <= counter[rd_sel] every cycle, giving 1-cycle read latency. The read reflects counter values before the same edge's update.
- running and done are decoded from registered state; they are never both 1.
- Reset mid-RUN aborts immediately to the reset values. No partial results are kept.
- Inputs are sampled as-is; the core supplies them synchronous to clock.

Test Plan:
- Reset, WINDOW=10: start at cycle 2, stall_in high for 3 cycles, RegWrite_wb_in high for 6 cycles -> DONE after 10 counted cycles; reads give cycles=10, stalls=3, retired=6; done=1, running=0.
- WINDOW=0: start, run 20 cycles, stop -> cycles=20 including the stop cycle, state DONE; a later start zeroes everything and running=1.
- Branch_in=1 for 4 cycles with Zero_in=1 in 2 of them; op_FA_in=10 for 3 cycles, op_FB_in=01 for 2 cycles, one cycle overlapping -> branches=4, taken=2, fwdA=3, fwdB=2, fwd_any=4.
- CNT_WIDTH=8, SATURATE=1, 300 cycles -> cycles=255, ovf[0]=1. Same run with SATURATE=0 -> cycles=44, ovf[0]=1.
- Priority checks:
  - start and stop in the same cycle during RUN -> DONE.
  - clear and start together -> IDLE, all reads 0.
  - reset pulsed low mid-RUN -> IDLE, rd_data=0, ovf=0 immediately, without waiting for a clock edge.
